// File: rtl/ctrl_multiciclo.sv
// Multicycle control FSM for the MIPS-subset datapath: sequences fetch/decode/execute/memory/writeback.
// Optional macro CTRL_PERF_EN adds free-running cycle_cnt/instr_cnt performance counters.
module ctrl_multiciclo #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       im_rd,
    output logic       seu_en,
    output logic       alu_src_b,
    output logic       rf_wr,
    output logic       dm_wr,
    output logic       dm_rd,
    output logic [1:0] dw_sel,
    output logic [1:0] rw_sel,
    output logic [1:0] next_pc_sel,
    output logic [3:0] alu_op,
    output logic [3:0] state,
    output logic       trap
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB       = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          waiting;
    logic          is_r;
    logic [3:0]    alu_r;
    logic [3:0]    alu_i;
    logic          seu_i;

    assign is_r    = (opcode == OP_RTYPE);
    assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    always_comb begin
        alu_r = ALU_AND;
        case (funct)
            FN_ADD:  alu_r = ALU_ADD;
            FN_SUB:  alu_r = ALU_SUB;
            FN_AND:  alu_r = ALU_AND;
            FN_OR:   alu_r = ALU_OR;
            FN_SLT:  alu_r = ALU_SLT;
            default: alu_r = ALU_AND;
        endcase
        alu_i = ALU_ADD;
        case (opcode)
            OP_ANDI: alu_i = ALU_AND;
            OP_ORI:  alu_i = ALU_OR;
            OP_SLTI: alu_i = ALU_SLT;
            default: alu_i = ALU_ADD;
        endcase
        seu_i = !((opcode == OP_ANDI) || (opcode == OP_ORI));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_d = S_EXEC_R;
                            FN_JR:   state_d = S_JUMP;
                            default: state_d = S_TRAP;
                        endcase
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J, OP_JAL:   state_d = S_JUMP;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB;
            S_WB:               state_d = S_FETCH;
            S_MEM_ADDR:         state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD, S_MEM_WR: if (mem_ready) state_d = S_FETCH;
            S_BRANCH, S_JUMP:   state_d = S_FETCH;
            S_TRAP:             state_d = S_TRAP;
            default:            state_d = S_TRAP;
        endcase

        // The TIMEOUT-th consecutive unanswered wait cycle traps; a ready in that cycle completes instead.
        if ((TIMEOUT != 0) && waiting && !mem_ready && (wait_q == CW'(TIMEOUT - 1)))
            state_d = S_TRAP;

        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if (waiting && !mem_ready)
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        pc_wr       = 1'b0;
        ir_wr       = 1'b0;
        im_rd       = 1'b0;
        seu_en      = 1'b0;
        alu_src_b   = 1'b0;
        rf_wr       = 1'b0;
        dm_wr       = 1'b0;
        dm_rd       = 1'b0;
        dw_sel      = 2'b00;
        rw_sel      = 2'b00;
        next_pc_sel = 2'b00;
        alu_op      = 4'b0000;
        trap        = 1'b0;
        case (state_q)
            S_FETCH: begin
                im_rd = 1'b1;
                ir_wr = mem_ready;
            end
            S_EXEC_R: alu_op = alu_r;
            S_EXEC_I: begin
                alu_src_b = 1'b1;
                alu_op    = alu_i;
                seu_en    = seu_i;
            end
            S_WB: begin
                alu_src_b = !is_r;
                alu_op    = is_r ? alu_r : alu_i;
                seu_en    = !is_r && seu_i;
                rf_wr     = 1'b1;
                rw_sel    = is_r ? 2'b01 : 2'b00;
                pc_wr     = 1'b1;
            end
            S_MEM_ADDR, S_MEM_RD, S_MEM_WR: begin
                alu_op    = ALU_ADD;
                alu_src_b = 1'b1;
                seu_en    = 1'b1;
                if (state_q == S_MEM_RD) begin
                    dm_rd  = 1'b1;
                    rf_wr  = mem_ready;
                    dw_sel = mem_ready ? 2'b01 : 2'b00;
                    pc_wr  = mem_ready;
                end
                if (state_q == S_MEM_WR) begin
                    dm_wr = 1'b1;
                    pc_wr = mem_ready;
                end
            end
            S_BRANCH: begin
                alu_op = ALU_SUB;
                pc_wr  = 1'b1;
                if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero))
                    next_pc_sel = 2'b01;
            end
            S_JUMP: begin
                pc_wr       = 1'b1;
                next_pc_sel = is_r ? 2'b11 : 2'b10;
                if (opcode == OP_JAL) begin
                    rf_wr  = 1'b1;
                    rw_sel = 2'b10;
                    dw_sel = 2'b10;
                end
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if ((state_q != S_IDLE) && (state_q != S_TRAP))
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (pc_wr)
                instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Bench for ctrl_multiciclo: per-instruction expected cycle traces built from the ISA rules, replayed cycle by cycle.
// Also covers CTRL_PERF_EN counters when that macro is defined.
module tb_ctrl_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_wr, ir_wr, im_rd, seu_en, alu_src_b, rf_wr, dm_wr, dm_rd, trap;
    logic [1:0] dw_sel, rw_sel, next_pc_sel;
    logic [3:0] alu_op, state;
`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    ctrl_multiciclo #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr), .im_rd(im_rd),
        .seu_en(seu_en), .alu_src_b(alu_src_b), .rf_wr(rf_wr), .dm_wr(dm_wr),
        .dm_rd(dm_rd), .dw_sel(dw_sel), .rw_sel(rw_sel), .next_pc_sel(next_pc_sel),
        .alu_op(alu_op), .state(state), .trap(trap)
`ifdef CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_wr, ir_wr, im_rd, seu_en, alu_src_b, rf_wr, dm_wr, dm_rd;
        logic [1:0] dw_sel, rw_sel, nps;
        logic [3:0] alu_op, st;
        logic       trap;
    } ctl_t;

    typedef struct {
        ctl_t exp;
        logic rdy;
        logic z;
    } ent_t;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

    ctl_t obs;
    assign obs = {pc_wr, ir_wr, im_rd, seu_en, alu_src_b, rf_wr, dm_wr, dm_rd,
                  dw_sel, rw_sel, next_pc_sel, alu_op, state, trap};

    int   total = 0;
    int   bad = 0;
    int   cyc_m = 0;
    int   ins_m = 0;
    ent_t tq[$];

    logic [5:0] tbl_op [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C,
                                6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] tbl_fn [16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input ctl_t e, input logic rdy, input logic z);
        ent_t en;
        en.exp = e;
        en.rdy = rdy;
        en.z   = z;
        tq.push_back(en);
    endtask

    // Instruction class, ALU operation and extension mode straight from the ISA table.
    task automatic classify(input logic [5:0] op, input logic [5:0] fn,
                            output int k, output logic [3:0] alu, output logic seu);
        k = K_ILL; alu = 4'b0000; seu = 1'b1;
        case (op)
            6'h00: case (fn)
                6'h20:   begin k = K_R; alu = 4'b0010; end
                6'h22:   begin k = K_R; alu = 4'b0110; end
                6'h24:   begin k = K_R; alu = 4'b0000; end
                6'h25:   begin k = K_R; alu = 4'b0001; end
                6'h2A:   begin k = K_R; alu = 4'b0111; end
                6'h08:   k = K_JR;
                default: k = K_ILL;
            endcase
            6'h08:   begin k = K_I; alu = 4'b0010; seu = 1'b1; end
            6'h0C:   begin k = K_I; alu = 4'b0000; seu = 1'b0; end
            6'h0D:   begin k = K_I; alu = 4'b0001; seu = 1'b0; end
            6'h0A:   begin k = K_I; alu = 4'b0111; seu = 1'b1; end
            6'h23:   k = K_LW;
            6'h2B:   k = K_SW;
            6'h04, 6'h05: k = K_BR;
            6'h02:   k = K_J;
            6'h03:   k = K_JAL;
            default: k = K_ILL;
        endcase
    endtask

    task automatic fetch_decode(input int fw);
        ctl_t e;
        e = '0; e.st = 4'd1; e.im_rd = 1'b1;
        repeat (fw) push(e, 1'b0, rb());
        e.ir_wr = 1'b1;
        push(e, 1'b1, rb());
        e = '0; e.st = 4'd2;
        push(e, rb(), rb());
    endtask

    task automatic play(input logic [5:0] op, input logic [5:0] fn, input string name);
        ent_t en;
        while (tq.size() > 0) begin
            en = tq.pop_front();
            @(negedge clk);
            opcode = op; funct = fn; zero = en.z; mem_ready = en.rdy;
            #1;
            chk($sformatf("%s_st%0d", name, en.exp.st), 32'(obs), 32'(en.exp));
            if (en.exp.st != 4'd0 && en.exp.st != 4'd15) cyc_m++;
            if (en.exp.pc_wr) ins_m++;
        end
    endtask

    // fw/mw: unanswered cycles before ready in fetch / data access; bz<0 picks a random zero flag for branches.
    task automatic exec(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                        input int bz, input string name);
        int         k;
        logic [3:0] alu;
        logic       seu;
        logic       z;
        ctl_t       e;
        classify(op, fn, k, alu, seu);
        fetch_decode(fw);
        e = '0;
        case (k)
            K_R: begin
                e.st = 4'd3; e.alu_op = alu;
                push(e, rb(), rb());
                e.st = 4'd8; e.rf_wr = 1'b1; e.rw_sel = 2'b01; e.pc_wr = 1'b1;
                push(e, rb(), rb());
            end
            K_I: begin
                e.st = 4'd4; e.alu_op = alu; e.alu_src_b = 1'b1; e.seu_en = seu;
                push(e, rb(), rb());
                e.st = 4'd8; e.rf_wr = 1'b1; e.rw_sel = 2'b00; e.pc_wr = 1'b1;
                push(e, rb(), rb());
            end
            K_LW, K_SW: begin
                e.st = 4'd5; e.alu_op = 4'b0010; e.alu_src_b = 1'b1; e.seu_en = 1'b1;
                push(e, rb(), rb());
                e.st = (k == K_LW) ? 4'd6 : 4'd7;
                if (k == K_LW) e.dm_rd = 1'b1; else e.dm_wr = 1'b1;
                repeat (mw) push(e, 1'b0, rb());
                if (k == K_LW) begin e.rf_wr = 1'b1; e.dw_sel = 2'b01; end
                e.pc_wr = 1'b1;
                push(e, 1'b1, rb());
            end
            K_BR: begin
                z = (bz < 0) ? rb() : 1'(bz);
                e.st = 4'd9; e.alu_op = 4'b0110; e.pc_wr = 1'b1;
                e.nps = ((op == 6'h04) ? z : !z) ? 2'b01 : 2'b00;
                push(e, rb(), z);
            end
            K_J, K_JAL, K_JR: begin
                e.st = 4'd10; e.pc_wr = 1'b1;
                e.nps = (k == K_JR) ? 2'b11 : 2'b10;
                if (k == K_JAL) begin e.rf_wr = 1'b1; e.rw_sel = 2'b10; e.dw_sel = 2'b10; end
                push(e, rb(), rb());
            end
            default: begin
                e.st = 4'd15; e.trap = 1'b1;
                repeat (20) push(e, rb(), rb());
            end
        endcase
        play(op, fn, name);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rst_async", 32'(obs), 32'd0);
`ifdef CTRL_PERF_EN
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        chk("rst_instr_cnt", instr_cnt, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_idle", 32'(obs), 32'd0);
        cyc_m = 0;
        ins_m = 0;
    endtask

    initial begin
        ctl_t e;
        int   idx;
        logic [5:0] op, fn;

        do_reset();

        exec(6'h00, 6'h20, 0, 0, -1, "add");
        exec(6'h23, 6'h00, 0, 3, -1, "lw_wait3");
        exec(6'h04, 6'h00, 0, 0, 1, "beq_z1");
        exec(6'h05, 6'h00, 0, 0, 1, "bne_z1");
        exec(6'h04, 6'h00, 0, 0, 0, "beq_z0");
        exec(6'h03, 6'h15, 0, 0, -1, "jal");
        exec(6'h00, 6'h08, 0, 0, -1, "jr");
        exec(6'h0C, 6'h3F, 0, 0, -1, "andi");
        exec(6'h2B, 6'h00, 2, 0, -1, "sw");
        exec(6'h08, 6'h00, 15, 0, -1, "fetch_ready_at_limit");
        exec(6'h2B, 6'h00, 0, 15, -1, "sw_ready_at_limit");

        for (int i = 0; i < 150; i++) begin
            idx = $urandom_range(0, 15);
            op  = tbl_op[idx];
            fn  = (idx <= 5) ? tbl_fn[idx] : 6'($urandom);
            exec(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), -1, "rnd");
        end

`ifdef CTRL_PERF_EN
        @(posedge clk);
        #1;
        chk("perf_cycle_cnt", cycle_cnt, 32'(cyc_m));
        chk("perf_instr_cnt", instr_cnt, 32'(ins_m));
`endif

        exec(6'h3F, 6'h00, 0, 0, -1, "illegal_op");
        do_reset();
        exec(6'h00, 6'h01, 1, 0, -1, "illegal_funct");
        do_reset();

        // Memory never answers: sixteen fetch cycles, then trap.
        e = '0; e.st = 4'd1; e.im_rd = 1'b1;
        repeat (16) push(e, 1'b0, rb());
        e = '0; e.st = 4'd15; e.trap = 1'b1;
        repeat (3) push(e, 1'b0, rb());
        play(6'h00, 6'h20, "fetch_timeout");
        do_reset();

        // Reset dropped in the middle of a store access.
        fetch_decode(0);
        e = '0; e.st = 4'd5; e.alu_op = 4'b0010; e.alu_src_b = 1'b1; e.seu_en = 1'b1;
        push(e, 1'b0, rb());
        e.st = 4'd7; e.dm_wr = 1'b1;
        push(e, 1'b0, rb());
        play(6'h2B, 6'h00, "sw_mid");
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("memwr2_dm_wr", 32'(dm_wr), 32'd1);
        chk("memwr2_state", 32'(state), 32'd7);
        do_reset();
        exec(6'h02, 6'h00, 0, 0, -1, "j_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_multiciclo.md
Name: ctrl_multiciclo

Overview:
Multicycle control FSM that sequences the MIPS-subset datapath (PC, register file, ALU, sign extender, data memory) over several cycles per instruction instead of one.
- Drives the same control set as the single-cycle control unit, plus PC/IR write strobes and memory request lines.
- Waits on a shared memory ready handshake.
- Traps on illegal instructions and on memory timeout.

Parameters:
TIMEOUT, 16, max consecutive cycles waiting on mem_ready in FETCH/MEM_RD/MEM_WR before entering TRAP; 0 disables the timeout.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  inst[31:26] from the IR; valid from DECODE onward
funct  input  6  inst[5:0] from the IR
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current im_rd/dm_rd/dm_wr access this cycle
pc_wr  output  1  PC load strobe
ir_wr  output  1  IR load strobe
im_rd  output  1  instruction memory read request
seu_en  output  1  1 = sign-extend imm, 0 = zero-extend
alu_src_b  output  1  0 = crt, 1 = inm_ext
rf_wr  output  1  register file write
dm_wr  output  1  data memory write request
dm_rd  output  1  data memory read request
dw_sel  output  2  write-data select: 00 alu, 01 data_rd, 10 pc_inc
rw_sel  output  2  write-register select: 00 rt, 01 rd, 10 r31
next_pc_sel  output  2  next PC select: 00 pc_inc, 01 pc_equal (branch), 10 pc_jump, 11 crs
alu_op  output  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
state  output  4  current state encoding (debug)
trap  output  1  1 while in TRAP

Behaviour:
Outputs and reset:
- All outputs are decoded combinationally from state, opcode, funct, zero and mem_ready. No output registers.
- Default value of every output is 0.
- rst_n low forces state=IDLE asynchronously, so all outputs are 0 immediately, including mid-access (e.g. dm_wr drops during MEM_WR).

State encodings:
- IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB=8, BRANCH=9, JUMP=10, TRAP=15.

Transitions:
- IDLE: go to FETCH next cycle.
- FETCH: im_rd=1. On mem_ready: ir_wr=1, go to DECODE. Otherwise stay.
- DECODE, by opcode:
  - 000000 R-type. funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt go to EXEC_R; 001000 jr goes to JUMP; any other funct goes to TRAP.
  - 001000 addi, 001100 andi, 001101 ori, 001010 slti go to EXEC_I.
  - 100011 lw, 101011 sw go to MEM_ADDR.
  - 000100 beq, 000101 bne go to BRANCH.
  - 000010 j, 000011 jal go to JUMP.
  - Any other opcode goes to TRAP.
- EXEC_R: alu_src_b=0, alu_op from funct. Go to WB.
- EXEC_I: alu_src_b=1, alu_op from opcode (addi ADD, andi AND, ori OR, slti SLT). seu_en=1 except andi/ori (0). Go to WB.
- WB: ALU controls held as in the previous EXEC state; rf_wr=1, dw_sel=00, rw_sel=01 (R) or 00 (I), pc_wr=1, next_pc_sel=00. Go to FETCH.
- MEM_ADDR: alu_op=ADD, alu_src_b=1, seu_en=1. lw goes to MEM_RD, sw goes to MEM_WR.
- MEM_RD: MEM_ADDR ALU controls held; dm_rd=1 until mem_ready. In the mem_ready cycle: rf_wr=1, dw_sel=01, rw_sel=00, pc_wr=1, then go to FETCH.
- MEM_WR: MEM_ADDR ALU controls held; dm_wr=1 until mem_ready. In the mem_ready cycle: pc_wr=1, then go to FETCH.
- BRANCH: alu_op=SUB, alu_src_b=0, pc_wr=1. next_pc_sel=01 if (beq&zero)|(bne&!zero), else 00. Go to FETCH.
- JUMP: pc_wr=1, next_pc_sel=10 (j/jal) or 11 (jr). jal additionally drives rf_wr=1, rw_sel=10, dw_sel=10. Go to FETCH.
- TRAP: trap=1, all strobes 0. Exit only by reset.

Handshake and timeout:
- mem_ready is ignored outside FETCH/MEM_RD/MEM_WR.
- A request stays asserted every cycle until the completing cycle and drops the cycle after.
- Wait counter: cleared on every state change; increments each wait-state cycle with mem_ready=0.
- When TIMEOUT!=0 and the counter reaches TIMEOUT, go to TRAP next cycle. If mem_ready=1 arrives in that same cycle, it wins.
- Counter width is $clog2(TIMEOUT+1), minimum 1.

Latency and invariants:
- Cycles per instruction with zero-wait memory: R/I 4, lw 4, sw 4, branch 3, jump 3.
- pc_wr is exactly one cycle per completed instruction.
- rf_wr and dm_wr are never asserted in the same cycle.

Optional Feature:
CTRL_PERF_EN:
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0 by rst_n.
  - cycle_cnt increments every cycle state is not IDLE or TRAP.
  - instr_cnt increments every cycle pc_wr=1.
  - Both wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset, mem_ready=1, add (op 000000, funct 100000) -> states 0,1,2,3,8,1. In WB: rf_wr=1, rw_sel=01, alu_op=0010, pc_wr=1, next_pc_sel=00.
2. lw, mem_ready low 3 cycles in MEM_RD -> dm_rd=1 for 4 cycles. rf_wr, pc_wr and dw_sel=01 only in the 4th cycle, then FETCH.
3. beq with zero=1 -> next_pc_sel=01. bne with zero=1 -> 00. Both take 3 cycles with pc_wr=1 only in BRANCH.
4. jal -> JUMP with rf_wr=1, rw_sel=10, dw_sel=10, next_pc_sel=10. jr (funct 001000) -> next_pc_sel=11, rf_wr=0. andi -> seu_en=0, alu_op=0000.
5. Opcode 111111 -> TRAP after DECODE, trap=1 held 20 cycles, all strobes 0. Separately, with TIMEOUT=16 and mem_ready=0 in FETCH -> TRAP after 16 FETCH cycles.
6. rst_n low in the 2nd MEM_WR cycle -> dm_wr=0 and state=0 with no clock edge. After release: IDLE then FETCH. With CTRL_PERF_EN defined, counters read 0.
